// File: rtl/instr_mem_loader.sv
// PIO instruction memory with a combinational fetch port and a host-side
// valid/ready burst load engine that writes a contiguous, wrapping block.
module instr_mem_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W:0]   load_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              drop_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W:0]     remaining;
  logic                xfer;
  logic                len_ok;

  function automatic logic len_in_range(input logic [ADDR_W:0] len);
    return (len != '0) && (len <= MAX_LEN);
  endfunction

  assign xfer        = wr_valid & wr_ready;
  assign len_ok      = len_in_range(load_len);
  assign instruction = mem[pc];

  // Cleared words decode as JMP 0, so a reset leaves the FSM spinning safely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (xfer) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      remaining  <= '0;
      wr_ready   <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_count <= '0;
      drop_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load_done <= 1'b0;
          if (load_start) begin
            if (len_ok) begin
              wr_ptr     <= load_addr;
              remaining  <= load_len;
              load_count <= '0;
              drop_err   <= 1'b0;
              wr_ready   <= 1'b1;
              busy       <= 1'b1;
              state      <= LOAD;
            end
          end else if (wr_valid) begin
            drop_err <= 1'b1;
          end
        end

        LOAD: begin
          if (xfer) begin
            wr_ptr     <= wr_ptr + 1'b1;
            remaining  <= remaining - 1'b1;
            load_count <= load_count + 1'b1;
            if (remaining == LAST_WORD) begin
              wr_ready  <= 1'b0;
              busy      <= 1'b0;
              load_done <= 1'b1;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          load_done <= 1'b0;
          if (wr_valid) drop_err <= 1'b1;
          state <= IDLE;
        end

        default: begin
          wr_ready  <= 1'b0;
          busy      <= 1'b0;
          load_done <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: a word-level memory model plus a
// completion scoreboard checked by an independent monitor.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  pc = '0;
  logic [15:0] instruction;
  logic        load_start = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [5:0]  load_len = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        busy;
  logic        load_done;
  logic [5:0]  load_count;
  logic        drop_err;

  instr_mem_loader #(.ADDR_W(5), .DATA_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .instruction (instruction),
    .load_start  (load_start),
    .load_addr   (load_addr),
    .load_len    (load_len),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .busy        (busy),
    .load_done   (load_done),
    .load_count  (load_count),
    .drop_err    (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    int cyc;
  } done_t;

  logic [15:0] ref_mem [32];
  done_t       exp_q[$];
  logic [15:0] fixed_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          pc_rand = 1'b0;
  int          last_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) ref_mem[i] = 16'h0000;
  endtask

  task automatic sweep(input string name);
    bit saved;
    saved = pc_rand;
    pc_rand = 1'b0;
    for (int i = 0; i < 32; i++) begin
      pc = 5'(i);
      #1;
      chk(name, instruction, ref_mem[i]);
    end
    pc_rand = saved;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: wr_valid always high, 1: toggles 1/0, 2: random gaps.
  // abort_after > 0 pulls rst_n low once that many words have been accepted.
  task automatic burst(input int a, input int n, input int mode, input int abort_after);
    int sent;
    int tries;
    bit xfer;
    logic [15:0] d;
    load_start = 1'b1;
    load_addr  = 5'(a);
    load_len   = 6'(n);
    @(posedge clk);
    #1;
    load_start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ready_after_start", wr_ready, 1);
    chk("drop_err_cleared", drop_err, 0);
    chk("count_cleared", load_count, 0);
    sent = 0;
    tries = 0;
    while (sent < n && tries < 400) begin
      case (mode)
        0: wr_valid = 1'b1;
        1: wr_valid = (tries % 2 == 0);
        default: wr_valid = ($urandom_range(0, 99) >= 30);
      endcase
      tries++;
      d = fixed_q.size() != 0 ? fixed_q[0] : 16'($urandom);
      wr_data = d;
      @(negedge clk);
      xfer = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (xfer) begin
        if (fixed_q.size() != 0) void'(fixed_q.pop_front());
        ref_mem[(a + sent) % 32] = d;
        sent++;
        if (sent == n) begin
          done_t e;
          e.count = n;
          e.cyc = cyc;
          exp_q.push_back(e);
        end
        if (abort_after > 0 && sent == abort_after) begin
          wr_valid = 1'b0;
          rst_n = 1'b0;
          clear_model();
          #1;
          chk("abort_busy", busy, 0);
          chk("abort_ready", wr_ready, 0);
          chk("abort_done", load_done, 0);
          sweep("abort_mem_clear");
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          idle_cycles(1);
          return;
        end
      end
    end
    wr_valid = 1'b0;
    if (sent < n) begin
      errors++;
      checks++;
      $display("FAIL burst_timeout: got %0d words expected %0d", sent, n);
    end
    last_len = n;
    idle_cycles(1);
  endtask

  task automatic bad_start(input int n);
    logic [5:0] cnt_before;
    cnt_before = load_count;
    load_start = 1'b1;
    load_addr  = 5'($urandom);
    load_len   = 6'(n);
    @(posedge clk);
    #1;
    load_start = 1'b0;
    chk("bad_len_busy", busy, 0);
    chk("bad_len_ready", wr_ready, 0);
    idle_cycles(1);
    chk("bad_len_busy_later", busy, 0);
    chk("bad_len_count", load_count, cnt_before);
  endtask

  // Monitor: every cycle the fetch port must match the model; every
  // load_done pulse retires one scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      chk("fetch", instruction, ref_mem[pc]);
      if (load_done) begin
        if (exp_q.size() == 0) begin
          chk("load_done_unexpected", 1, 0);
        end else begin
          done_t e;
          e = exp_q.pop_front();
          chk("done_count", load_count, e.count);
          chk("done_cycle", cyc, e.cyc);
          chk("done_busy", busy, 0);
          chk("done_ready", wr_ready, 0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (pc_rand) pc = 5'($urandom);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    #1;
    rst_n = 1'b0;
    #1;
    sweep("reset_mem");
    chk("reset_ready", wr_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", load_done, 0);
    chk("reset_count", load_count, 0);
    chk("reset_drop", drop_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);

    fixed_q = '{16'hE021, 16'hE042, 16'h0004};
    burst(4, 3, 0, 0);
    pc = 5'd5;
    #1;
    chk("pc5_word", instruction, 16'hE042);
    sweep("after_burst_4_3");
    chk("count_hold_3", load_count, 3);

    burst(30, 4, 1, 0);
    sweep("after_wrap_burst");
    chk("count_hold_4", load_count, 4);

    bad_start(0);
    bad_start(33);
    sweep("after_bad_len");
    chk("drop_before_stray", drop_err, 0);
    wr_valid = 1'b1;
    wr_data  = 16'hDEAD;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    chk("drop_set", drop_err, 1);
    idle_cycles(3);
    chk("drop_sticky", drop_err, 1);
    sweep("stray_not_written");

    // Write-through timing at pc=7: old word in the write cycle, new one after.
    load_start = 1'b1;
    load_addr  = 5'd7;
    load_len   = 6'd1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    chk("drop_cleared_by_start", drop_err, 0);
    pc       = 5'd7;
    wr_valid = 1'b1;
    wr_data  = 16'hE03F;
    @(negedge clk);
    chk("wr_cycle_old_word", instruction, ref_mem[7]);
    @(posedge clk);
    #1;
    wr_valid   = 1'b0;
    ref_mem[7] = 16'hE03F;
    begin
      done_t e;
      e.count = 1;
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    chk("wr_next_new_word", instruction, 16'hE03F);
    idle_cycles(1);

    burst(10, 5, 0, 2);
    chk("post_abort_count", load_count, 0);
    burst(12, 5, 0, 0);
    sweep("after_fresh_load");

    pc_rand = 1'b1;
    burst($urandom_range(0, 31), 32, 2, 0);
    sweep("after_full_fill");
    for (int k = 0; k < 6; k++) begin
      burst($urandom_range(0, 31), $urandom_range(1, 32), 2, 0);
      idle_cycles($urandom_range(0, 3));
      chk("count_hold_rand", load_count, last_len);
    end
    pc_rand = 1'b0;
    sweep("final_mem");

    idle_cycles(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- 32 x 16-bit PIO instruction memory plus a host-side burst load engine.
- Sits directly upstream of the state-machine FSM. It takes the FSM's program counter and returns the instruction at that address combinationally, in the same cycle.
- A valid/ready write channel lets the host load a contiguous, wrapping block of instructions while the FSM keeps fetching.

Parameters:
- ADDR_W, 5, address width; memory depth is 2^ADDR_W.
- DATA_W, 16, instruction width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; clears memory and load engine.
- pc  input  ADDR_W  fetch address from the FSM program counter.
- instruction  output  DATA_W  mem[pc]; combinational read.
- load_start  input  1  one-cycle pulse that starts a burst load.
- load_addr  input  ADDR_W  first address of the burst; sampled on load_start.
- load_len  input  ADDR_W+1  word count, 1..32; sampled on load_start.
- wr_data  input  DATA_W  instruction word to write.
- wr_valid  input  1  host has a word on wr_data.
- wr_ready  output  1  engine accepts a word this cycle.
- busy  output  1  burst in progress.
- load_done  output  1  one-cycle pulse after the last word is written.
- load_count  output  ADDR_W+1  words written in the current or last burst.
- drop_err  output  1  sticky flag: word offered while idle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All memory words become 16'h0000, which decodes as unconditional JMP 0.
  - State IDLE.
  - wr_ready=0, busy=0, load_done=0, load_count=0, drop_err=0.
  - instruction = 16'h0000 for any pc.
- Read path:
  - instruction = mem[pc], combinational, no latency.
  - Write in cycle N to address A: instruction with pc=A shows the old word during cycle N and the new word from cycle N+1.
- States:
  - IDLE: wr_ready=0, busy=0.
    - load_start=1 with load_len in 1..32: latch wr_ptr=load_addr and remaining=load_len, clear load_count, clear drop_err, go to LOAD.
    - load_start with load_len=0 or load_len>32: ignored; stay IDLE; no flags change.
    - wr_valid=1 while IDLE and not load_start: word discarded, drop_err set to 1.
  - LOAD: wr_ready=1, busy=1.
    - On wr_valid && wr_ready: mem[wr_ptr] <= wr_data.
    - wr_ptr <= wr_ptr+1 modulo 32; 31 wraps to 0.
    - remaining decrements by 1; load_count increments by 1.
    - When the accepted word is the last (remaining==1): go to DONE next cycle.
    - wr_valid low: hold; no state change.
    - load_start during LOAD: ignored.
  - DONE: one cycle only.
    - load_done=1, wr_ready=0, busy=0.
    - Unconditionally returns to IDLE.
    - load_start in DONE is ignored.
    - wr_valid in DONE sets drop_err.
- Handshake:
  - A transfer occurs only in a cycle where wr_valid and wr_ready are both high.
  - wr_ready depends only on state, never on wr_valid.
  - Back-to-back transfers give one word per cycle.
- Counters:
  - load_count holds its final value after DONE until the next accepted load_start.
  - load_len=32 fills all 32 words; wr_ptr ends at load_addr after wrapping.
- Concurrent fetch: the FSM may fetch from an address being written; no stall is generated. The host owns program coherence.
- Reset mid-LOAD:
  - Engine returns to IDLE.
  - Memory is fully cleared, including words already written.
  - No load_done pulse is produced.

Test Plan:
- Reset, then sweep pc 0..31 -> instruction=16'h0000 at every address; wr_ready=0, busy=0, load_done=0.
- load_start, load_addr=4, load_len=3; wr_data E021, E042, 0004 on consecutive cycles with wr_valid high -> words written at 4, 5, 6; load_done pulses exactly 1 cycle after the third transfer; load_count=3; pc=5 reads E042.
- load_addr=30, load_len=4, wr_valid toggled 1/0 -> words land at 30, 31, 0, 1 in order; no writes in wr_valid-low cycles; load_count=4.
- load_len=0, then load_len=33 -> busy stays 0, no writes; next wr_valid=1 while IDLE sets drop_err=1; drop_err stays set until the next valid load_start clears it.
- Write E03F to address 7 while pc=7 -> instruction shows the old word in the write cycle and E03F in the next cycle.
- Assert rst_n low after 2 of 5 words in a burst -> busy=0 immediately; all memory reads 0000; no load_done pulse; a fresh load then works normally.
